// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared encodings for the fetch controller and decode.
// FSM states, halt cause codes, the per-cycle action selector, the
// canonical NOP and the RV opcode constants used by decode.
package fetch_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fc_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_FETCH    = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_MISALIGN = 2'd3
  } halt_cause_t;

  // One action per cycle, already resolved in priority order.
  typedef enum logic [2:0] {
    ACT_ADVANCE,
    ACT_REDIRECT,
    ACT_MISALIGN,
    ACT_ILLEGAL,
    ACT_FETCH_FAULT,
    ACT_STALL,
    ACT_HALTED
  } fc_action_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_controller_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load in EX
// and the source registers of the instruction sitting in IF/ID.
module hazard_detect
  import fetch_ctrl_pkg::*;
(
  input  logic       if_id_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);

  // x0 is never a real dependency, so a load targeting it cannot stall.
  always_comb begin
    hazard = if_id_valid && ex_mem_read && (ex_rd != 5'd0) &&
             ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: front-end sequencer owning PC and the IF/ID register.
// Handles load-use stalls, EX redirects with IF/ID flush, and a sticky halt
// on fetch, illegal-instruction and misaligned-target faults.
// Optional build macro FETCH_CTRL_PERF_EN adds stall/flush perf counters.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned           XLEN       = 64,
  parameter logic [XLEN-1:0]       RESET_PC   = '0,
  parameter int unsigned           IMEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     imem_instr,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_instr_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            stall,
  output logic            id_ex_bubble,
  output logic            halted,
  output logic [1:0]      halt_cause
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fc_state_t       state;
  halt_cause_t     cause_q;
  logic [XLEN-1:0] pc_q;
  logic            if_id_valid_q;
  logic            hazard;
  fc_action_t      act;

  hazard_detect u_hazard (
    .if_id_valid (if_id_valid_q),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  // Resolve this cycle's single action; redirect outranks everything so a
  // wrong-path instruction in IF/ID can neither stall nor fault.
  always_comb begin
    act = ACT_ADVANCE;
    if (state == ST_HALT) begin
      act = ACT_HALTED;
    end else if (ex_branch_taken) begin
      act = (ex_branch_target[1:0] != 2'b00) ? ACT_MISALIGN : ACT_REDIRECT;
    end else if (if_id_valid_q && !id_instr_valid) begin
      act = ACT_ILLEGAL;
    end else if (pc_q >= IMEM_LIMIT) begin
      act = ACT_FETCH_FAULT;
    end else if (hazard) begin
      act = ACT_STALL;
    end
  end

  // Stall/bubble are combinational; IF/ID valid is masked while halted.
  always_comb begin
    stall        = (act == ACT_STALL);
    id_ex_bubble = act inside {ACT_REDIRECT, ACT_MISALIGN, ACT_ILLEGAL,
                               ACT_STALL, ACT_HALTED};
    halted       = (state == ST_HALT);
    if_id_valid  = if_id_valid_q && (state != ST_HALT);
    halt_cause   = cause_q;
    pc           = pc_q;
  end

  // RUN/HALT state machine together with the PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_RUN;
      cause_q       <= CAUSE_NONE;
      pc_q          <= RESET_PC;
      if_id_pc      <= '0;
      if_id_instr   <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      case (act)
        ACT_REDIRECT: begin
          pc_q          <= ex_branch_target;
          if_id_valid_q <= 1'b0;
        end
        ACT_MISALIGN: begin
          state   <= ST_HALT;
          cause_q <= CAUSE_MISALIGN;
        end
        ACT_ILLEGAL: begin
          state   <= ST_HALT;
          cause_q <= CAUSE_ILLEGAL;
        end
        ACT_FETCH_FAULT: begin
          state   <= ST_HALT;
          cause_q <= CAUSE_FETCH;
        end
        ACT_ADVANCE: begin
          if_id_instr   <= imem_instr;
          if_id_pc      <= pc_q;
          if_id_valid_q <= 1'b1;
          pc_q          <= pc_q + PC_STEP;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  // Saturating perf counters; neither action occurs in HALT so they freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (act == ACT_STALL && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (act == ACT_REDIRECT && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vector table plus randomized run against a
// behavioural model of the fetch controller.
module tb_fetch_controller;

  localparam int unsigned IMEM = 1024;

  logic        clk;
  logic        reset;
  logic [31:0] imem_instr;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_instr_valid, ex_mem_read, ex_branch_taken;
  logic [63:0] ex_branch_target;
  logic [63:0] pc, if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid, stall, id_ex_bubble, halted;
  logic [1:0]  halt_cause;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  fetch_controller #(
    .XLEN       (64),
    .RESET_PC   (64'd0),
    .IMEM_BYTES (IMEM)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_instr       (imem_instr),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_instr_valid   (id_instr_valid),
    .ex_rd            (ex_rd),
    .ex_mem_read      (ex_mem_read),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .pc               (pc),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid),
    .stall            (stall),
    .id_ex_bubble     (id_ex_bubble),
    .halted           (halted),
    .halt_cause       (halt_cause)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_flush_cnt   (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        bt;
    logic [63:0] tgt;
    logic        mr;
    logic [4:0]  rd, rs1, rs2;
    logic        iv;
    logic [63:0] e_pc;
    logic        e_valid;
    logic [63:0] e_ifpc;
    logic        e_stall, e_bubble, e_halted;
    logic [1:0]  e_cause;
  } vec_t;

  function automatic vec_t mk(input int rst, input int bt, input logic [63:0] tgt,
                              input int mr, input int rd, input int rs1, input int rs2,
                              input int iv, input logic [63:0] epc, input int ev,
                              input logic [63:0] eifpc, input int es, input int eb,
                              input int eh, input int ec);
    vec_t v;
    v.rst = 1'(rst); v.bt = 1'(bt); v.tgt = tgt; v.mr = 1'(mr);
    v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.iv = 1'(iv);
    v.e_pc = epc; v.e_valid = 1'(ev); v.e_ifpc = eifpc;
    v.e_stall = 1'(es); v.e_bubble = 1'(eb); v.e_halted = 1'(eh); v.e_cause = 2'(ec);
    return v;
  endfunction

  // Behavioural model state
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid, m_halt;
  logic [1:0]  m_cause;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  task automatic model_reset();
    m_pc = 64'd0; m_ifpc = 64'd0; m_instr = 32'h13; m_valid = 1'b0;
    m_halt = 1'b0; m_cause = 2'd0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  function automatic logic m_hazard();
    return m_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  task automatic model_check();
    logic illegal, fault, e_stall, e_bub;
    illegal = m_valid && !id_instr_valid;
    fault   = m_pc >= 64'(IMEM);
    e_stall = !m_halt && !ex_branch_taken && !illegal && !fault && m_hazard();
    e_bub   = m_halt || ex_branch_taken || illegal || e_stall;
    chk("rnd_pc", pc, m_pc);
    chk("rnd_valid", 64'(if_id_valid), 64'(m_valid && !m_halt));
    if (m_valid && !m_halt) begin
      chk("rnd_ifpc", if_id_pc, m_ifpc);
      chk("rnd_instr", 64'(if_id_instr), 64'(m_instr));
    end
    chk("rnd_stall", 64'(stall), 64'(e_stall));
    chk("rnd_bubble", 64'(id_ex_bubble), 64'(e_bub));
    chk("rnd_halted", 64'(halted), 64'(m_halt));
    chk("rnd_cause", 64'(halt_cause), 64'(m_cause));
`ifdef FETCH_CTRL_PERF_EN
    chk("rnd_perf_stall", 64'(perf_stall_cnt), 64'(m_stall_cnt));
    chk("rnd_perf_flush", 64'(perf_flush_cnt), 64'(m_flush_cnt));
`endif
  endtask

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_halt) begin
      // absorbing
    end else if (ex_branch_taken) begin
      if (ex_branch_target[1:0] != 2'b00) begin
        m_halt = 1'b1; m_cause = 2'd3;
      end else begin
        m_pc = ex_branch_target; m_valid = 1'b0;
        if (m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      end
    end else if (m_valid && !id_instr_valid) begin
      m_halt = 1'b1; m_cause = 2'd2;
    end else if (m_pc >= 64'(IMEM)) begin
      m_halt = 1'b1; m_cause = 2'd1;
    end else if (m_hazard()) begin
      if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    end else begin
      m_instr = imem_instr; m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
    end
  endtask

  vec_t vecs[$];

  initial begin
    // Directed cycle-by-cycle table starting right after reset.
    //            rst bt tgt          mr rd rs1 rs2 iv | pc          v  ifpc       st bb h  c
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h0,      0, 64'h0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h4,      1, 64'h0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    1, 5, 0, 5, 1,  64'h8,      1, 64'h4,     1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    1, 0, 0, 0, 1,  64'h8,      1, 64'h4,     0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 64'h40,   1, 5, 5, 0, 1,  64'hC,      1, 64'h8,     0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    1, 5, 5, 0, 1,  64'h40,     0, 64'h0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 64'h3FC,  0, 0, 0, 0, 1,  64'h44,     1, 64'h40,    0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h3FC,    0, 64'h0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h400,    1, 64'h3FC,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h400,    0, 64'h0,     0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 64'h80,   1, 5, 5, 0, 1,  64'h400,    0, 64'h0,     0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 64'h0,    0, 0, 0, 0, 1,  64'h400,    0, 64'h0,     0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h0,      0, 64'h0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 64'h42,   0, 0, 0, 0, 1,  64'h4,      1, 64'h0,     0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h4,      0, 64'h0,     0, 1, 1, 3));
    vecs.push_back(mk(1, 0, 64'h0,    0, 0, 0, 0, 1,  64'h4,      0, 64'h0,     0, 1, 1, 3));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h0,      0, 64'h0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 0,  64'h4,      1, 64'h0,     0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 0, 1,  64'h4,      0, 64'h0,     0, 1, 1, 2));

    reset = 1'b1; imem_instr = 32'h0010_0093; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_instr_valid = 1'b1; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    ex_branch_target = 64'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pc", pc, 64'd0);
    chk("rst_ifpc", if_id_pc, 64'd0);
    chk("rst_instr", 64'(if_id_instr), 64'h13);
    chk("rst_valid", 64'(if_id_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_cause", 64'(halt_cause), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_bubble", 64'(id_ex_bubble), 64'd0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; ex_branch_taken = vecs[i].bt; ex_branch_target = vecs[i].tgt;
      ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd; id_rs1 = vecs[i].rs1;
      id_rs2 = vecs[i].rs2; id_instr_valid = vecs[i].iv;
      #1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_valid", i), 64'(if_id_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("v%0d_ifpc", i), if_id_pc, vecs[i].e_ifpc);
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d_bubble", i), 64'(id_ex_bubble), 64'(vecs[i].e_bubble));
      chk($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].e_halted));
      chk($sformatf("v%0d_cause", i), 64'(halt_cause), 64'(vecs[i].e_cause));
      @(posedge clk); @(negedge clk);
    end

    // Randomized run against the model, starting from a fresh reset.
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    model_reset();
`ifdef FETCH_CTRL_PERF_EN
    reset = 1'b0; #1;
    chk("perf_rst_stall", 64'(perf_stall_cnt), 64'd0);
    chk("perf_rst_flush", 64'(perf_flush_cnt), 64'd0);
`endif
    for (int c = 0; c < 4000; c++) begin
      reset = (m_halt && $urandom_range(0, 5) == 0) || ($urandom_range(0, 599) == 0);
      imem_instr = $urandom;
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom_range(0, 1));
      id_instr_valid = ($urandom_range(0, 149) != 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      ex_branch_target = 64'($urandom_range(0, IMEM / 4 + 6)) * 64'd4;
      if ($urandom_range(0, 11) == 0)
        ex_branch_target = ex_branch_target + 64'($urandom_range(1, 3));
      #1;
      model_check();
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the pipelined core's front end: owns the PC register and IF/ID pipeline register, and drives the stall/redirect decisions that the fetch/decode stage consumes. Detects load-use hazards, applies taken-branch redirects from EX with IF/ID flush, and enters a sticky halt on instruction-memory, illegal-instruction or misaligned-target faults. Sits between instruction memory, the fetch/decode stage and the EX stage.

## Interface
- XLEN, 64, PC and target width
- RESET_PC, 64'd0, PC value loaded on reset
- IMEM_BYTES, 1024, instruction memory size; PC >= IMEM_BYTES is a fetch fault

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_instr  in  32  instruction read at pc (combinational memory)
- id_rs1, id_rs2  in  5  source registers decoded from if_id_instr
- id_instr_valid  in  1  decode reports known opcode for if_id_instr
- ex_rd  in  5  destination of instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  EX resolved a taken branch
- ex_branch_target  in  XLEN  redirect address
- pc  out  XLEN  current fetch address
- if_id_pc  out  XLEN  PC of instruction in IF/ID
- if_id_instr  out  32  instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- stall  out  1  load-use stall this cycle (PC, IF/ID hold)
- id_ex_bubble  out  1  ID/EX must load a NOP this cycle
- halted  out  1  core halted
- halt_cause  out  2  0 none, 1 fetch fault, 2 illegal instr, 3 misaligned target

## Operation
- FSM: RUN, HALT. Reset -> RUN. HALT is absorbing until reset.
- Per RUN cycle, priority highest first:
  - Redirect: ex_branch_taken=1. If ex_branch_target[1:0]!=0 -> HALT, cause 3. Else pc<=target, if_id_valid<=0, id_ex_bubble=1, stall=0.
  - Illegal: if_id_valid && !id_instr_valid -> HALT, cause 2.
  - Fetch fault: pc >= IMEM_BYTES -> HALT, cause 1 (faulting word never enters IF/ID).
  - Load-use: if_id_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2) -> stall=1, id_ex_bubble=1; pc and IF/ID hold.
  - Normal: if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4.
- Redirect beats simultaneous load-use and simultaneous illegal in IF/ID (wrong-path instruction is squashed, never faults).
- In HALT: pc, IF/ID frozen; if_id_valid=0 combinationally masked; stall=0; id_ex_bubble=1 every cycle.
- pc+4 wraps modulo 2^XLEN; wrap lands below IMEM_BYTES only via overflow, no special case.
- halt_cause captured on HALT entry, held until reset.

## Timing
- Reset values: pc=RESET_PC, if_id_pc=0, if_id_instr=32'h00000013 (NOP), if_id_valid=0, halted=0, halt_cause=0, stall=0, id_ex_bubble=0.
- First fetch: cycle after reset deasserts; first valid IF/ID one cycle later.
- stall, id_ex_bubble: combinational from current-cycle inputs and state.
- Load-use stall lasts exactly one cycle (load leaves EX next cycle).
- Redirect: target appears on pc next cycle; target instruction valid in IF/ID two cycles after ex_branch_taken. Branch penalty two bubbles (IF/ID flush + ID/EX bubble).
- halted rises the cycle after the fault condition is sampled.
- reset mid-stall, mid-redirect or in HALT: all state to reset values next edge; reset dominates all inputs.

## Configuration
- FETCH_CTRL_PERF_EN defined: adds outputs perf_stall_cnt and perf_flush_cnt (32 bits each), reset 0, incremented on each stall cycle and each redirect, saturating at all-ones, frozen in HALT.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Package fetch_ctrl_pkg: FSM state encoding, halt_cause codes, NOP encoding 32'h00000013, opcode constants shared with decode.
- Sub-module hazard_detect: combinational load-use comparator (if_id_valid, ex_mem_read, ex_rd, id_rs1, id_rs2 -> hazard).

## Test plan
- Reset then 3 cycles, imem_instr=addi -> pc 0,4,8; if_id_valid=1 from cycle 2 with if_id_pc=0.
- Load in EX ex_rd=5, id_rs2=5 -> stall=1, id_ex_bubble=1 one cycle, pc holds; ex_rd=0 same case -> no stall.
- ex_branch_taken=1 target 0x40 with simultaneous load-use -> no stall, pc=0x40 next cycle, if_id_valid=0, bubble=1.
- Taken branch to 0x42 -> halted=1, halt_cause=3, pc frozen; id_instr_valid=0 in IF/ID with no branch -> cause 2.
- Branch to 0x3FC then sequential -> fetch at 0x400 gives halted=1, cause 1, 0x400 word never valid in IF/ID.
- Assert reset while halted -> pc=RESET_PC, halted=0, cause 0; with FETCH_CTRL_PERF_EN, counters read 0.
